// File: rtl/id_ex_if.sv
// Bundle of decode-side inputs, forwarding sources and EX-stage outputs for the ID/EX pipeline register.
// The master drives decode and forwarding inputs. The slave is the ID/EX stage.
interface id_ex_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [4:0]  id_rd_addr;
  logic [4:0]  id_aluop;
  logic [4:0]  id_ctrl;
  logic        flush;
  logic        exm_reg_write;
  logic [4:0]  exm_rd_addr;
  logic [31:0] exm_result;
  logic        mwb_reg_write;
  logic [4:0]  mwb_rd_addr;
  logic [31:0] mwb_data;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [4:0]  select;
  logic [31:0] ex_pc;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd_addr;
  logic [2:0]  ex_ctrl;
  logic        ex_valid;
  logic        stall;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_aluop, id_ctrl, flush,
           exm_reg_write, exm_rd_addr, exm_result,
           mwb_reg_write, mwb_rd_addr, mwb_data,
    input  data1, data2, select, ex_pc, ex_store_data, ex_rd_addr,
           ex_ctrl, ex_valid, stall
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_aluop, id_ctrl, flush,
           exm_reg_write, exm_rd_addr, exm_result,
           mwb_reg_write, mwb_rd_addr, mwb_data,
    output data1, data2, select, ex_pc, ex_store_data, ex_rd_addr,
           ex_ctrl, ex_valid, stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, latch-time MEM/WB bypass and EX-time
// operand forwarding from EX/MEM and MEM/WB.
module id_ex_stage (
  input  logic clk,
  input  logic rst_n,
  id_ex_if.slave bus
);

  // Handshake: id_valid acts as "valid" from decode and ~stall acts as "ready". Decode advances only
  // when both are high. A flush kills the entering instruction regardless of stall, so no extra cycle is used.
  logic        ex_valid_q;
  logic [31:0] ex_pc_q;
  logic [31:0] ex_rs1_data_q;
  logic [31:0] ex_rs2_data_q;
  logic [31:0] ex_imm_q;
  logic [4:0]  ex_rs1_addr_q;
  logic [4:0]  ex_rs2_addr_q;
  logic [4:0]  ex_rd_addr_q;
  logic [4:0]  ex_aluop_q;
  logic        ex_alusrc1_q;
  logic        ex_alusrc2_q;
  logic [2:0]  ex_ctrl_q;

  logic        stall;
  logic        bubble;
  logic [31:0] id_rs1_byp;
  logic [31:0] id_rs2_byp;
  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;

  // ex_ctrl_q[2] is MEM_READ: a load whose rd feeds the decode instruction.
  assign stall = ex_valid_q && ex_ctrl_q[2] && (ex_rd_addr_q != 5'd0) && bus.id_valid &&
                 ((ex_rd_addr_q == bus.id_rs1_addr) || (ex_rd_addr_q == bus.id_rs2_addr));

  assign bubble = bus.flush || stall || !bus.id_valid;

  // Register file does not yet see the MEM/WB write in this cycle, so capture it on the way in.
  always_comb begin
    id_rs1_byp = bus.id_rs1_data;
    id_rs2_byp = bus.id_rs2_data;
    if (bus.mwb_reg_write && (bus.mwb_rd_addr != 5'd0) && (bus.mwb_rd_addr == bus.id_rs1_addr))
      id_rs1_byp = bus.mwb_data;
    if (bus.mwb_reg_write && (bus.mwb_rd_addr != 5'd0) && (bus.mwb_rd_addr == bus.id_rs2_addr))
      id_rs2_byp = bus.mwb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= 32'd0;
      ex_rs1_data_q <= 32'd0;
      ex_rs2_data_q <= 32'd0;
      ex_imm_q      <= 32'd0;
      ex_rs1_addr_q <= 5'd0;
      ex_rs2_addr_q <= 5'd0;
      ex_rd_addr_q  <= 5'd0;
      ex_aluop_q    <= 5'd0;
      ex_alusrc1_q  <= 1'b0;
      ex_alusrc2_q  <= 1'b0;
      ex_ctrl_q     <= 3'd0;
    end else if (bubble) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= 32'd0;
      ex_rs1_data_q <= 32'd0;
      ex_rs2_data_q <= 32'd0;
      ex_imm_q      <= 32'd0;
      ex_rs1_addr_q <= 5'd0;
      ex_rs2_addr_q <= 5'd0;
      ex_rd_addr_q  <= 5'd0;
      ex_aluop_q    <= 5'd0;
      ex_alusrc1_q  <= 1'b0;
      ex_alusrc2_q  <= 1'b0;
      ex_ctrl_q     <= 3'd0;
    end else begin
      ex_valid_q    <= 1'b1;
      ex_pc_q       <= bus.id_pc;
      ex_rs1_data_q <= id_rs1_byp;
      ex_rs2_data_q <= id_rs2_byp;
      ex_imm_q      <= bus.id_imm;
      ex_rs1_addr_q <= bus.id_rs1_addr;
      ex_rs2_addr_q <= bus.id_rs2_addr;
      ex_rd_addr_q  <= bus.id_rd_addr;
      ex_aluop_q    <= bus.id_aluop;
      ex_alusrc1_q  <= bus.id_ctrl[4];
      ex_alusrc2_q  <= bus.id_ctrl[3];
      ex_ctrl_q     <= bus.id_ctrl[2:0];
    end
  end

  // EX/MEM wins over MEM/WB; x0 is never forwarded; nothing is forwarded into a bubble.
  always_comb begin
    fwd_rs1 = 32'd0;
    fwd_rs2 = 32'd0;
    if (ex_valid_q) begin
      if (bus.exm_reg_write && (bus.exm_rd_addr != 5'd0) && (bus.exm_rd_addr == ex_rs1_addr_q))
        fwd_rs1 = bus.exm_result;
      else if (bus.mwb_reg_write && (bus.mwb_rd_addr != 5'd0) && (bus.mwb_rd_addr == ex_rs1_addr_q))
        fwd_rs1 = bus.mwb_data;
      else
        fwd_rs1 = ex_rs1_data_q;

      if (bus.exm_reg_write && (bus.exm_rd_addr != 5'd0) && (bus.exm_rd_addr == ex_rs2_addr_q))
        fwd_rs2 = bus.exm_result;
      else if (bus.mwb_reg_write && (bus.mwb_rd_addr != 5'd0) && (bus.mwb_rd_addr == ex_rs2_addr_q))
        fwd_rs2 = bus.mwb_data;
      else
        fwd_rs2 = ex_rs2_data_q;
    end
  end

  assign bus.data1         = !ex_valid_q ? 32'd0 : (ex_alusrc1_q ? ex_pc_q : fwd_rs1);
  assign bus.data2         = !ex_valid_q ? 32'd0 : (ex_alusrc2_q ? ex_imm_q : fwd_rs2);
  assign bus.ex_store_data = fwd_rs2;
  assign bus.select        = ex_aluop_q;
  assign bus.ex_pc         = ex_pc_q;
  assign bus.ex_rd_addr    = ex_rd_addr_q;
  assign bus.ex_ctrl       = ex_ctrl_q;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.stall         = stall;

endmodule
